// File: rtl/axis_arb_pkg.sv
// rtl/axis_arb_pkg.sv - shared types and index helpers for the stream arbiters
package axis_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

    // Starting from the top index makes port 0 the first winner after reset
    function automatic int rst_last_grant(input int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// rtl/axis_rr_pick.sv - combinational round-robin picker starting after the last winner
module axis_rr_pick
    import axis_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any_req
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        gnt_idx = '0;
        any_req = 1'b0;
        idx     = last;
        for (int k = 0; k < N; k++) begin
            idx = IDX_W'(next_idx(int'(idx), N));
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                gnt_idx = idx;
            end
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// rtl/axis_rr_arbiter.sv - packet-granular round-robin arbiter onto one stream port
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1,
    parameter int MAX_BEATS  = 0,
    parameter int IDX_W      = $clog2(N)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N-1:0]              s_tvalid,
    output logic [N-1:0]              s_tready,
    input  logic [N*DATA_WIDTH-1:0]   s_tdata,
    input  logic [N*DATA_WIDTH/8-1:0] s_tkeep,
    input  logic [N-1:0]              s_tlast,
    input  logic [N*USER_WIDTH-1:0]   s_tuser,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic [DATA_WIDTH-1:0]     m_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_tkeep,
    output logic                      m_tlast,
    output logic [USER_WIDTH-1:0]     m_tuser,
    output logic [IDX_W-1:0]          m_tid,
    output logic                      busy,
    output logic                      limit_err
);

    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int CNT_W  = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'((MAX_BEATS > 0) ? MAX_BEATS - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(rst_last_grant(N));

    state_t           state;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] pick_idx;
    logic [CNT_W-1:0] beat_cnt;
    logic             any_req;
    logic             locked;
    logic             beat;
    logic             sel_last;
    logic             at_limit;
    logic             release_pkt;

    axis_rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (s_tvalid),
        .last    (last_grant),
        .gnt_idx (pick_idx),
        .any_req (any_req)
    );

    assign locked      = (state == LOCK);
    assign sel_last    = s_tlast[grant];
    assign at_limit    = (MAX_BEATS > 0) && (beat_cnt == CNT_LIMIT);
    assign beat        = m_tvalid & m_tready;
    assign release_pkt = beat & (sel_last | at_limit);
    assign busy        = locked;

    // Only the granted port is ever selected, so junk on idle ports cannot leak out
    always_comb begin
        m_tvalid = 1'b0;
        m_tdata  = '0;
        m_tkeep  = '0;
        m_tlast  = 1'b0;
        m_tuser  = '0;
        m_tid    = '0;
        s_tready = '0;
        if (locked) begin
            m_tvalid        = s_tvalid[grant];
            m_tdata         = s_tdata[grant*DATA_WIDTH +: DATA_WIDTH];
            m_tkeep         = s_tkeep[grant*KEEP_W +: KEEP_W];
            m_tuser         = s_tuser[grant*USER_WIDTH +: USER_WIDTH];
            m_tlast         = sel_last | at_limit;
            m_tid           = grant;
            s_tready[grant] = m_tready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= LAST_RST;
            beat_cnt   <= '0;
            limit_err  <= 1'b0;
        end else begin
            limit_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant <= pick_idx;
                        state <= LOCK;
                    end
                end
                LOCK: begin
                    if (release_pkt) begin
                        state      <= IDLE;
                        last_grant <= grant;
                        beat_cnt   <= '0;
                        limit_err  <= at_limit & ~sel_last;
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
Shares one AXI-Stream master port between N AXI-Stream slave requesters using packet-granular round-robin arbitration. A grant is held from the first beat of a packet until its tlast beat handshakes, so packets are never interleaved. An optional beat limit forcibly releases a requester that never asserts tlast. It sits between the shell's stream producers (DMA channels, user kernels) and a single shared stream sink. Requester ports use the flattened CHANNEL*width vector layout of the shell stream interface.

Parameters:
N, 4, number of requester ports (2..16)
DATA_WIDTH, 32, tdata width per port (multiple of 8)
USER_WIDTH, 1, tuser width per port
MAX_BEATS, 0, beat limit per grant; 0 disables the limit
IDX_W, $clog2(N), width of the grant index (derived, not overridden)

Ports:
clk  in  1  clock; all logic is on the rising edge
rst  in  1  synchronous, active-high reset
s_tvalid  in  N  requester valid, bit i = port i
s_tready  out  N  requester ready
s_tdata  in  N*DATA_WIDTH  port i at [i*DATA_WIDTH +: DATA_WIDTH]
s_tkeep  in  N*DATA_WIDTH/8  byte keep per port
s_tlast  in  N  end of packet per port
s_tuser  in  N*USER_WIDTH  sideband per port
m_tvalid  out  1  shared output valid
m_tready  in  1  shared output ready
m_tdata  out  DATA_WIDTH  muxed data
m_tkeep  out  DATA_WIDTH/8  muxed keep
m_tlast  out  1  muxed last; forced to 1 on a limit-release beat
m_tuser  out  USER_WIDTH  muxed user
m_tid  out  IDX_W  index of the granted port
busy  out  1  high in the LOCK state
limit_err  out  1  one-cycle pulse when MAX_BEATS forces a release

Behaviour:
- Reset: state=IDLE, grant=0, last_grant=N-1 (port 0 has first priority), beat_cnt=0. After reset: s_tready=0, m_tvalid=0, busy=0, limit_err=0, m_tid=0, m_tdata/keep/last/user=0.
- IDLE:
  - If any s_tvalid is high, pick the first set bit searching from last_grant+1 upward, wrapping modulo N.
  - Load grant; go to LOCK on the next edge. Arbitration costs exactly 1 idle cycle per packet.
  - No s_tready is asserted in IDLE.
- LOCK, combinational mux from port g=grant:
  - m_tvalid=s_tvalid[g]; s_tready[g]=m_tready; all other s_tready bits=0.
  - m_tdata/keep/user come from port g; m_tid=g.
  - Outputs are 0 when not in LOCK.
- Beat counting: beat = m_tvalid & m_tready. Each beat increments beat_cnt (width $clog2(MAX_BEATS+1), minimum 1).
- Release on a tlast beat: go to IDLE, last_grant<=g, beat_cnt<=0.
- Release on the limit (MAX_BEATS>0): a beat with beat_cnt==MAX_BEATS-1 and s_tlast[g]=0 releases the grant. m_tlast is forced to 1 on that beat, limit_err pulses high the next cycle, last_grant<=g. The remainder of that requester's packet is arbitrated later as a new packet.
- Other requesters asserting or deasserting tvalid during LOCK have no effect.
- Requester g dropping tvalid mid-packet: the grant is held (no timeout on idle gaps). With m_tready low, everything stalls and beat_cnt holds.
- Single requester back-to-back: every packet is followed by one IDLE bubble.
- Reset asserted mid-packet: immediate return to reset values on the next edge. No flush; the sink sees a truncated packet.
- No AXIS protocol checking on inputs beyond the above; X on unselected ports must not propagate.

Decomposition:
- Package axis_arb_pkg holds:
  - state_t enum {IDLE, LOCK};
  - a function that returns the next index with wrap;
  - a constant for the reset last_grant (N-1) via a parameterised function.
- One sub-module, axis_rr_pick: purely combinational. Inputs req[N], last[IDX_W]. Outputs gnt_idx and any_req. It is reused by future AXI4 read/write channel arbiters.

Test Plan:
- Single port: port 2 sends a 3-beat packet (D0..D2, tlast on D2) with m_tready=1. Expect 1 idle cycle, then 3 beats with m_tid=2 and m_tlast on the 3rd beat only, busy high for 3 cycles.
- Round-robin: all 4 ports hold 2-beat packets from reset. Grant order is 0,1,2,3,0; each packet is contiguous and followed by exactly one bubble.
- Lock: port 1 mid-packet while port 0 raises tvalid. Port 0's s_tready stays 0 until port 1's tlast beat; port 0 is granted next.
- Backpressure: m_tready toggles 1,0,0,1 during a 4-beat packet. Data holds stable while stalled, beat order is preserved, and no beat is duplicated or lost.
- Limit: MAX_BEATS=4, port 3 sends 6 beats with tlast on beat 6. Beat 4 carries m_tlast=1, limit_err pulses once, the other ports are served, then port 3's beats 5-6 follow as a new packet.
- Reset: rst asserted for 1 cycle on beat 2 of a 5-beat packet. The next cycle shows m_tvalid=0, busy=0, s_tready=0; the next arbitration starts from port 0.
